// File: rtl/hs_profiler_array_if.sv
// hs_profiler_array_if: handshake observation, freeze and read-port bundle for hs_profiler_array
// master drives finish, ap_start/ap_ready/ap_done/ap_continue and rd_en/rd_ch/rd_sel;
// slave (the profiler) returns rd_valid, rd_data and frozen.
interface hs_profiler_array_if #(
  parameter int NUM_CH = 27,
  parameter int CNT_W = 32,
  parameter int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) ();
  logic finish;
  logic [NUM_CH-1:0] ap_start;
  logic [NUM_CH-1:0] ap_ready;
  logic [NUM_CH-1:0] ap_done;
  logic [NUM_CH-1:0] ap_continue;
  logic rd_en;
  logic [CH_W-1:0] rd_ch;
  logic [2:0] rd_sel;
  logic rd_valid;
  logic [CNT_W-1:0] rd_data;
  logic frozen;
  modport master (
    output finish, ap_start, ap_ready, ap_done, ap_continue, rd_en, rd_ch, rd_sel,
    input rd_valid, rd_data, frozen
  );
  modport slave (
    input finish, ap_start, ap_ready, ap_done, ap_continue, rd_en, rd_ch, rd_sel,
    output rd_valid, rd_data, frozen
  );
endinterface

// File: rtl/hs_profiler_array.sv
// hs_profiler_array: per-channel ap_ctrl handshake profiler with saturating counters, freeze and registered readout
// Ports: clock, reset (asynchronous, active high); bus (slave modport) with finish, per-channel
// ap_start/ap_ready/ap_done/ap_continue, read request rd_en/rd_ch/rd_sel and outputs rd_valid/rd_data/frozen.
module hs_profiler_array #(
  parameter int NUM_CH = 27,
  parameter int CNT_W = 32,
  parameter int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input logic clock,
  input logic reset,
  hs_profiler_array_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
  typedef logic [CNT_W-1:0] cnt_t;
  state_t st [NUM_CH];
  state_t nx [NUM_CH];
  cnt_t busy [NUM_CH];
  cnt_t stall [NUM_CH];
  cnt_t done_cnt [NUM_CH];
  cnt_t ready_cnt [NUM_CH];
  cnt_t lat [NUM_CH];
  cnt_t last_lat [NUM_CH];
  cnt_t max_lat [NUM_CH];
  cnt_t sel;
  logic frozen;
  logic en;
  function automatic cnt_t inc(input cnt_t v, input logic e);
    return (e && !(&v)) ? v + cnt_t'(1) : v;
  endfunction
  // the finish edge itself already blocks updates, so a coincident done is dropped
  assign en = !frozen && !bus.finish;
  assign bus.frozen = frozen;
  // BUSY-with-done and HOLD-with-continue share one exit: continue low parks in HOLD
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      nx[i] = st[i];
      if (st[i] == IDLE)
        nx[i] = bus.ap_start[i] ? BUSY : IDLE;
      else if (st[i] == BUSY && !bus.ap_done[i])
        nx[i] = BUSY;
      else if (st[i] == BUSY || bus.ap_continue[i])
        nx[i] = !bus.ap_continue[i] ? HOLD : bus.ap_start[i] ? BUSY : IDLE;
    end
  end
  // out-of-range channels never match, leaving sel at zero
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (bus.rd_ch == CH_W'(i))
        sel = bus.rd_sel == 3'd0 ? busy[i] :
              bus.rd_sel == 3'd1 ? stall[i] :
              bus.rd_sel == 3'd2 ? done_cnt[i] :
              bus.rd_sel == 3'd3 ? ready_cnt[i] :
              bus.rd_sel == 3'd4 ? last_lat[i] :
              bus.rd_sel == 3'd5 ? max_lat[i] : '0;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frozen <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        st[i] <= IDLE;
        busy[i] <= '0;
        stall[i] <= '0;
        done_cnt[i] <= '0;
        ready_cnt[i] <= '0;
        lat[i] <= '0;
        last_lat[i] <= '0;
        max_lat[i] <= '0;
      end
    end else begin
      frozen <= frozen | bus.finish;
      bus.rd_valid <= bus.rd_en;
      bus.rd_data <= bus.rd_en ? sel : '0;
      if (en)
        for (int i = 0; i < NUM_CH; i++) begin
          st[i] <= nx[i];
          busy[i] <= inc(busy[i], st[i] == BUSY);
          stall[i] <= inc(stall[i], st[i] == HOLD);
          done_cnt[i] <= inc(done_cnt[i], st[i] == BUSY && bus.ap_done[i]);
          ready_cnt[i] <= inc(ready_cnt[i], bus.ap_ready[i]);
          // fresh entry into BUSY, including a back-to-back restart, reloads 1
          lat[i] <= (nx[i] == BUSY && (st[i] != BUSY || bus.ap_done[i])) ? cnt_t'(1) : inc(lat[i], st[i] == BUSY);
          if (st[i] == BUSY && bus.ap_done[i]) begin
            last_lat[i] <= lat[i];
            if (lat[i] > max_lat[i])
              max_lat[i] <= lat[i];
          end
        end
    end
  end
endmodule

// File: tb/tb_hs_profiler_array.sv
// tb_hs_profiler_array: directed self-checking bench for hs_profiler_array
module tb_hs_profiler_array;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int passed = 0;
  hs_profiler_array_if #(.NUM_CH(27), .CNT_W(32), .CH_W(5)) bus ();
  hs_profiler_array_if #(.NUM_CH(2), .CNT_W(4), .CH_W(1)) sbus ();
  hs_profiler_array #(.NUM_CH(27), .CNT_W(32), .CH_W(5)) dut (.clock(clock), .reset(reset), .bus(bus));
  hs_profiler_array #(.NUM_CH(2), .CNT_W(4), .CH_W(1)) dut4 (.clock(clock), .reset(reset), .bus(sbus));
  always #5 clock = ~clock;
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic rd(input int ch, input int s, output logic [31:0] d, output logic v);
    bus.rd_en = 1'b1;
    bus.rd_ch = 5'(ch);
    bus.rd_sel = 3'(s);
    step;
    d = bus.rd_data;
    v = bus.rd_valid;
    bus.rd_en = 1'b0;
  endtask
  task automatic test_reset;
    logic [31:0] d;
    logic v;
    int chs [2] = '{0, 26};
    for (int c = 0; c < 2; c++)
      for (int s = 0; s < 6; s++) begin
        rd(chs[c], s, d, v);
        total++;
        if (d !== 32'd0 || v !== 1'b1)
          $display("FAIL reset ch%0d sel%0d: got data=%0d valid=%b, want data=0 valid=1", chs[c], s, d, v);
        else passed++;
      end
    step;
    total++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'd0 || bus.frozen !== 1'b0)
      $display("FAIL reset_idle_outputs: got valid=%b data=%0d frozen=%b, want 0 0 0", bus.rd_valid, bus.rd_data, bus.frozen);
    else passed++;
  endtask
  task automatic test_single_run;
    logic [31:0] d;
    logic v;
    logic [31:0] exp [6] = '{32'd5, 32'd0, 32'd1, 32'd1, 32'd5, 32'd5};
    bus.ap_start[3] = 1'b1;
    step;
    bus.ap_start[3] = 1'b0;
    bus.ap_ready[3] = 1'b1;
    step;
    bus.ap_ready[3] = 1'b0;
    step;
    rd(3, 0, d, v);
    total++;
    if (d !== 32'd2 || v !== 1'b1)
      $display("FAIL live_read_busy ch3: got data=%0d valid=%b, want data=2 valid=1", d, v);
    else passed++;
    step;
    bus.ap_done[3] = 1'b1;
    bus.ap_continue[3] = 1'b1;
    step;
    bus.ap_done[3] = 1'b0;
    bus.ap_continue[3] = 1'b0;
    repeat (3) step;
    for (int s = 0; s < 6; s++) begin
      rd(3, s, d, v);
      total++;
      if (d !== exp[s] || v !== 1'b1)
        $display("FAIL single ch3 sel%0d: got data=%0d valid=%b, want data=%0d valid=1", s, d, v, exp[s]);
      else passed++;
    end
  endtask
  task automatic test_hold;
    logic [31:0] d;
    logic v;
    logic [31:0] exp [6] = '{32'd3, 32'd4, 32'd2, 32'd0, 32'd1, 32'd2};
    bus.ap_start[5] = 1'b1;
    step;
    bus.ap_start[5] = 1'b0;
    step;
    bus.ap_done[5] = 1'b1;
    step;
    bus.ap_done[5] = 1'b0;
    repeat (3) step;
    bus.ap_continue[5] = 1'b1;
    bus.ap_start[5] = 1'b1;
    step;
    bus.ap_start[5] = 1'b0;
    bus.ap_done[5] = 1'b1;
    step;
    bus.ap_done[5] = 1'b0;
    bus.ap_continue[5] = 1'b0;
    step;
    for (int s = 0; s < 6; s++) begin
      rd(5, s, d, v);
      total++;
      if (d !== exp[s] || v !== 1'b1)
        $display("FAIL hold ch5 sel%0d: got data=%0d valid=%b, want data=%0d valid=1", s, d, v, exp[s]);
      else passed++;
    end
  endtask
  task automatic test_back_to_back;
    logic [31:0] exp [6] = '{32'd12, 32'd0, 32'd3, 32'd0, 32'd2, 32'd7};
    bus.ap_start[0] = 1'b1;
    step;
    bus.ap_start[0] = 1'b0;
    repeat (2) step;
    {bus.ap_start[0], bus.ap_done[0], bus.ap_continue[0]} = 3'b111;
    step;
    {bus.ap_start[0], bus.ap_done[0], bus.ap_continue[0]} = 3'b000;
    repeat (6) step;
    {bus.ap_start[0], bus.ap_done[0], bus.ap_continue[0]} = 3'b111;
    step;
    {bus.ap_start[0], bus.ap_done[0], bus.ap_continue[0]} = 3'b000;
    step;
    {bus.ap_done[0], bus.ap_continue[0]} = 2'b11;
    step;
    {bus.ap_done[0], bus.ap_continue[0]} = 2'b00;
    step;
    bus.rd_en = 1'b1;
    bus.rd_ch = 5'd0;
    for (int s = 0; s < 6; s++) begin
      bus.rd_sel = 3'(s);
      step;
      total++;
      if (bus.rd_data !== exp[s] || bus.rd_valid !== 1'b1)
        $display("FAIL b2b ch0 sel%0d: got data=%0d valid=%b, want data=%0d valid=1", s, bus.rd_data, bus.rd_valid, exp[s]);
      else passed++;
    end
    bus.rd_en = 1'b0;
  endtask
  task automatic test_saturate;
    logic [3:0] exp [6] = '{4'd15, 4'd0, 4'd1, 4'd0, 4'd15, 4'd15};
    sbus.ap_start[0] = 1'b1;
    step;
    sbus.ap_start[0] = 1'b0;
    repeat (19) step;
    {sbus.ap_done[0], sbus.ap_continue[0]} = 2'b11;
    step;
    {sbus.ap_done[0], sbus.ap_continue[0]} = 2'b00;
    for (int s = 0; s < 6; s++) begin
      sbus.rd_en = 1'b1;
      sbus.rd_ch = 1'b0;
      sbus.rd_sel = 3'(s);
      step;
      sbus.rd_en = 1'b0;
      total++;
      if (sbus.rd_data !== exp[s] || sbus.rd_valid !== 1'b1)
        $display("FAIL saturate sel%0d: got data=%0d valid=%b, want data=%0d valid=1", s, sbus.rd_data, sbus.rd_valid, exp[s]);
      else passed++;
    end
  endtask
  task automatic test_freeze;
    logic [31:0] d;
    logic v;
    logic [31:0] exp [6] = '{32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    bus.ap_start[1] = 1'b1;
    step;
    bus.ap_start[1] = 1'b0;
    repeat (3) step;
    bus.finish = 1'b1;
    {bus.ap_done[1], bus.ap_continue[1], bus.ap_ready[1]} = 3'b111;
    step;
    bus.finish = 1'b0;
    bus.ap_start[1] = 1'b1;
    repeat (3) step;
    {bus.ap_start[1], bus.ap_done[1], bus.ap_continue[1], bus.ap_ready[1]} = 4'b0000;
    total++;
    if (bus.frozen !== 1'b1)
      $display("FAIL frozen_flag: got %b, want 1", bus.frozen);
    else passed++;
    for (int s = 0; s < 6; s++) begin
      rd(1, s, d, v);
      total++;
      if (d !== exp[s] || v !== 1'b1)
        $display("FAIL freeze ch1 sel%0d: got data=%0d valid=%b, want data=%0d valid=1", s, d, v, exp[s]);
      else passed++;
    end
    rd(0, 0, d, v);
    total++;
    if (d !== 32'd12 || v !== 1'b1)
      $display("FAIL freeze ch0 busy: got data=%0d valid=%b, want data=12 valid=1", d, v);
    else passed++;
    rd(30, 0, d, v);
    total++;
    if (d !== 32'd0 || v !== 1'b1)
      $display("FAIL bad_channel rd_ch=30: got data=%0d valid=%b, want data=0 valid=1", d, v);
    else passed++;
    rd(1, 6, d, v);
    total++;
    if (d !== 32'd0 || v !== 1'b1)
      $display("FAIL bad_sel rd_sel=6: got data=%0d valid=%b, want data=0 valid=1", d, v);
    else passed++;
  endtask
  task automatic test_reset_mid_freeze;
    logic [31:0] d;
    logic v;
    int chs [3] = '{0, 1, 3};
    bus.rd_en = 1'b1;
    bus.rd_ch = 5'd0;
    bus.rd_sel = 3'd0;
    step;
    reset = 1'b1;
    #2;
    total++;
    if (bus.frozen !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 32'd0)
      $display("FAIL async_reset: got frozen=%b valid=%b data=%0d, want 0 0 0", bus.frozen, bus.rd_valid, bus.rd_data);
    else passed++;
    bus.rd_en = 1'b0;
    step;
    reset = 1'b0;
    step;
    for (int c = 0; c < 3; c++) begin
      rd(chs[c], 0, d, v);
      total++;
      if (d !== 32'd0 || v !== 1'b1)
        $display("FAIL post_reset ch%0d busy: got data=%0d valid=%b, want data=0 valid=1", chs[c], d, v);
      else passed++;
    end
    bus.ap_start[2] = 1'b1;
    step;
    bus.ap_start[2] = 1'b0;
    step;
    rd(2, 0, d, v);
    total++;
    if (d !== 32'd1 || v !== 1'b1)
      $display("FAIL post_reset counting ch2 busy: got data=%0d valid=%b, want data=1 valid=1", d, v);
    else passed++;
  endtask
  initial begin
    bus.finish = 1'b0;
    bus.ap_start = '0;
    bus.ap_ready = '0;
    bus.ap_done = '0;
    bus.ap_continue = '0;
    bus.rd_en = 1'b0;
    bus.rd_ch = '0;
    bus.rd_sel = '0;
    sbus.finish = 1'b0;
    sbus.ap_start = '0;
    sbus.ap_ready = '0;
    sbus.ap_done = '0;
    sbus.ap_continue = '0;
    sbus.rd_en = 1'b0;
    sbus.rd_ch = '0;
    sbus.rd_sel = '0;
    repeat (2) step;
    reset = 1'b0;
    step;
    test_reset;
    test_single_run;
    test_hold;
    test_back_to_back;
    test_saturate;
    test_freeze;
    test_reset_mid_freeze;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
